// File: rtl/step_pulse_timing_pkg.sv
// Shared state encoding and default driver timing for the step pulse timing block.
// Both the RTL and the bench take their timing defaults from here.
package step_pulse_timing_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DIR_SETUP  = 2'd1,
    PULSE_HIGH = 2'd2,
    PULSE_LOW  = 2'd3
  } step_state_e;

  localparam int StepNumAxes         = 3;
  localparam int StepDirSetupCycles  = 4;
  localparam int StepPulseHighCycles = 3;
  localparam int StepPulseLowCycles  = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/step_pulse_timing_axis_step_timer.sv
// One axis channel: accepts a step request and shapes it into a driver-legal
// pulse with direction setup, exact high width and minimum low width.
module axis_step_timer
  import step_pulse_timing_pkg::*;
#(
  parameter int DirSetupCycles  = StepDirSetupCycles,
  parameter int PulseHighCycles = StepPulseHighCycles,
  parameter int PulseLowCycles  = StepPulseLowCycles
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic step_req,
  input  logic dir_req,
  output logic step_ready,
  output logic step_out,
  output logic dir_out,
  output logic busy
);

  localparam int CntW = $clog2(max3(DirSetupCycles, PulseHighCycles, PulseLowCycles) + 1);
  localparam logic [CntW-1:0] DirLoad  = CntW'(DirSetupCycles - 1);
  localparam logic [CntW-1:0] HighLoad = CntW'(PulseHighCycles - 1);
  localparam logic [CntW-1:0] LowLoad  = CntW'(PulseLowCycles - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [CntW-1:0] CntZero  = '0;

  step_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            step_q, step_d;
  logic            dir_q, dir_d;
  logic            accept;

  // rst_n gates ready so nothing is advertised while the channel is held in reset
  assign step_ready = rst_n & enable & (state_q == IDLE);
  assign accept     = step_req & step_ready;
  assign step_out   = step_q;
  assign dir_out    = dir_q;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (dir_req == dir_q) begin
            state_d = PULSE_HIGH;
            step_d  = 1'b1;
            cnt_d   = HighLoad;
          end else begin
            // direction only ever moves here, so it is stable for the whole pulse
            state_d = DIR_SETUP;
            dir_d   = dir_req;
            cnt_d   = DirLoad;
          end
        end
      end
      DIR_SETUP: begin
        if (cnt_q == CntZero) begin
          state_d = PULSE_HIGH;
          step_d  = 1'b1;
          cnt_d   = HighLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      PULSE_HIGH: begin
        if (cnt_q == CntZero) begin
          state_d = PULSE_LOW;
          step_d  = 1'b0;
          cnt_d   = LowLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      PULSE_LOW: begin
        if (cnt_q == CntZero) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/step_pulse_timing.sv
// Final stage before the stepper-driver header: NumAxes independent pulse
// shapers with per-axis back-pressure toward the step generator.
module step_pulse_timing
  import step_pulse_timing_pkg::*;
#(
  parameter int NumAxes         = StepNumAxes,
  parameter int DirSetupCycles  = StepDirSetupCycles,
  parameter int PulseHighCycles = StepPulseHighCycles,
  parameter int PulseLowCycles  = StepPulseLowCycles
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NumAxes-1:0] step_req,
  input  logic [NumAxes-1:0] dir_req,
  output logic [NumAxes-1:0] step_ready,
  output logic [NumAxes-1:0] step_out,
  output logic [NumAxes-1:0] dir_out,
  output logic               busy
);

  logic [NumAxes-1:0] axis_busy;

  for (genvar i = 0; i < NumAxes; i++) begin : g_axis
    axis_step_timer #(
      .DirSetupCycles (DirSetupCycles),
      .PulseHighCycles(PulseHighCycles),
      .PulseLowCycles (PulseLowCycles)
    ) u_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .step_req  (step_req[i]),
      .dir_req   (dir_req[i]),
      .step_ready(step_ready[i]),
      .step_out  (step_out[i]),
      .dir_out   (dir_out[i]),
      .busy      (axis_busy[i])
    );
  end

  assign busy = |axis_busy;

endmodule

// File: tb/tb_step_pulse_timing.sv
// Bench for step_pulse_timing: a per-axis "age since accept" model checked
// every cycle, plus directed scenarios with hand-computed cycle expectations.
module tb_step_pulse_timing;
  import step_pulse_timing_pkg::*;

  localparam int NA = StepNumAxes;
  localparam int DS = StepDirSetupCycles;
  localparam int PH = StepPulseHighCycles;
  localparam int PL = StepPulseLowCycles;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic [NA-1:0] step_req = '0;
  logic [NA-1:0] dir_req = '0;
  logic [NA-1:0] step_ready, step_out, dir_out;
  logic          busy;

  int n_chk = 0;
  int n_fail = 0;

  step_pulse_timing dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .step_req(step_req),
    .dir_req(dir_req), .step_ready(step_ready), .step_out(step_out),
    .dir_out(dir_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each axis is either free or "age" cycles past its accept edge.
  // Its sequence lasts s+PH+PL cycles, s = DS on a direction change else 0,
  // and step_out is high for ages s+1 .. s+PH.
  bit m_active[NA];
  int m_age[NA];
  int m_s[NA];
  bit m_dir[NA];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NA; i++) begin
        m_active[i] = 0; m_age[i] = 0; m_s[i] = 0; m_dir[i] = 0;
      end
    end else begin
      for (int i = 0; i < NA; i++) begin
        if (m_active[i]) begin
          m_age[i]++;
          if (m_age[i] > m_s[i] + PH + PL) m_active[i] = 0;
        end else if (enable && step_req[i]) begin
          m_active[i] = 1;
          m_age[i]    = 1;
          m_s[i]      = (dir_req[i] != m_dir[i]) ? DS : 0;
          m_dir[i]    = dir_req[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [NA-1:0] e_step, e_dir, e_rdy;
    logic          e_busy;
    e_step = '0; e_dir = '0; e_rdy = '0; e_busy = 1'b0;
    for (int i = 0; i < NA; i++) begin
      e_dir[i]  = m_dir[i];
      e_step[i] = m_active[i] && (m_age[i] > m_s[i]) && (m_age[i] <= m_s[i] + PH);
      e_rdy[i]  = rst_n && enable && !m_active[i];
      e_busy    = e_busy | m_active[i];
    end
    chk("model_step_out", 32'(step_out), 32'(e_step));
    chk("model_dir_out", 32'(dir_out), 32'(e_dir));
    chk("model_step_ready", 32'(step_ready), 32'(e_rdy));
    chk("model_busy", 32'(busy), 32'(e_busy));
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  initial begin
    int hi, rises, rdy_seen;
    logic prev;

    // reset held with all requests up
    step_req = '1;
    tick(); tick();
    chk("rst_step_out", 32'(step_out), 32'h0);
    chk("rst_dir_out", 32'(dir_out), 32'h0);
    chk("rst_step_ready", 32'(step_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    step_req = '0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(step_ready), 32'h7);

    // single step, same direction on axis 0
    step_req = 3'b001; dir_req = 3'b000;
    tick();
    step_req = '0;
    chk("single_hi_t1", 32'(step_out[0]), 32'h1);
    tick(); chk("single_hi_t2", 32'(step_out[0]), 32'h1);
    tick(); chk("single_hi_t3", 32'(step_out[0]), 32'h1);
    tick(); chk("single_lo_t4", 32'(step_out[0]), 32'h0);
    chk("single_busy_t4", 32'(busy), 32'h1);
    tick(); chk("single_rdy_t5", 32'(step_ready[0]), 32'h0);
    tick(); chk("single_rdy_t6", 32'(step_ready[0]), 32'h1);

    // direction change on axis 1
    step_req = 3'b010; dir_req = 3'b010;
    tick();
    step_req = '0;
    chk("dirchg_dir_t1", 32'(dir_out[1]), 32'h1);
    chk("dirchg_step_t1", 32'(step_out[1]), 32'h0);
    tick(); tick(); tick();
    chk("dirchg_step_t4", 32'(step_out[1]), 32'h0);
    tick();
    chk("dirchg_step_t5", 32'(step_out[1]), 32'h1);
    hi = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      hi += step_out[1];
      chk("dirchg_dir_stable", 32'(dir_out[1]), 32'h1);
    end
    chk("dirchg_high_width", 32'(hi), 32'd3);

    // back-to-back on axis 2, request held 20 edges
    dir_req = 3'b010;
    step_req = 3'b100;
    rises = 0; hi = 0; prev = step_out[2];
    for (int k = 0; k < 20; k++) begin
      tick();
      if (step_out[2] && !prev) rises++;
      hi += step_out[2];
      prev = step_out[2];
    end
    step_req = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (step_out[2] && !prev) rises++;
      hi += step_out[2];
      prev = step_out[2];
    end
    chk("b2b_pulse_count", 32'(rises), 32'd4);
    chk("b2b_high_cycles", 32'(hi), 32'd12);

    // enable dropped right after an accept
    step_req = 3'b001; dir_req = 3'b010;
    tick();
    enable = 1'b0;
    hi = step_out[0]; rdy_seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      hi += step_out[0];
      rdy_seen += step_ready[0];
    end
    chk("en_drop_high_width", 32'(hi), 32'd3);
    chk("en_drop_ready_blocked", 32'(rdy_seen), 32'd0);
    enable = 1'b1;
    step_req = '0;
    tick();
    chk("en_restore_ready", 32'(step_ready), 32'h7);

    // async reset during PULSE_HIGH after a direction change on axis 0
    step_req = 3'b001; dir_req = 3'b011;
    tick();
    step_req = '0;
    for (int k = 0; k < 4; k++) tick();
    chk("arst_pre_high", 32'(step_out[0]), 32'h1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_step_drop", 32'(step_out[0]), 32'h0);
    chk("arst_dir_clear", 32'(dir_out), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_after_dir", 32'(dir_out), 32'h0);
    chk("arst_after_busy", 32'(busy), 32'h0);
    chk("arst_after_ready", 32'(step_ready), 32'h7);

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      enable   = ($urandom_range(0, 9) != 0);
      step_req = NA'($urandom);
      dir_req  = NA'($urandom);
      tick();
    end
    step_req = '0;
    for (int k = 0; k < 15; k++) tick();
    chk("final_idle_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
